// File: rtl/mu_pkg.sv
// Shared definitions for the μ ledger: state encoding, error codes and default widths.
// Error codes are sticky: the first one raised stays until reset or clear.
package mu_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_EXHAUSTED = 2'd1,
    ST_SATURATED = 2'd2
  } state_t;

  localparam logic [7:0] ERR_NONE     = 8'h00;
  localparam logic [7:0] ERR_BUDGET   = 8'h01;
  localparam logic [7:0] ERR_SATURATE = 8'h02;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_NUM_MODULES = 64;
  localparam int DEF_MU_WIDTH    = 32;
  localparam int DEF_COST_WIDTH  = 8;

endpackage

// File: rtl/mu_sat_add.sv
// Saturating adder: sum clamps at all-ones of W bits and ovf flags the clamp.
// The addend may be wider than the accumulator.
module mu_sat_add #(
  parameter int W  = 32,
  parameter int BW = 32
) (
  input  logic [W-1:0]  a,
  input  logic [BW-1:0] b,
  output logic [W-1:0]  sum,
  output logic          ovf
);

  // One guard bit above the wider operand so the carry is never lost.
  localparam int XW = ((W > BW) ? W : BW) + 1;

  logic [XW-1:0] wide;

  assign wide = XW'(a) + XW'(b);
  assign ovf  = |wide[XW-1:W];
  assign sum  = ovf ? {W{1'b1}} : wide[W-1:0];

endmodule

// File: rtl/mu_ledger.sv
// Multi-channel μ ledger: charges accumulate into a global total and per-module counters,
// guarded by an all-or-nothing budget ceiling and saturating arithmetic.
module mu_ledger
  import mu_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int NUM_MODULES = DEF_NUM_MODULES,
  parameter int MU_WIDTH    = DEF_MU_WIDTH,
  parameter int COST_WIDTH  = DEF_COST_WIDTH,
  localparam int MOD_W      = $clog2(NUM_MODULES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            chg_valid,
  input  logic [NUM_CH*COST_WIDTH-1:0] chg_cost,
  input  logic [NUM_CH*MOD_W-1:0]      chg_module,
  output logic                         chg_ready,
  input  logic [MU_WIDTH-1:0]          budget,
  input  logic                         budget_en,
  input  logic                         clear,
  input  logic [MOD_W-1:0]             q_module,
  output logic [MU_WIDTH-1:0]          q_mu,
  output logic [MU_WIDTH-1:0]          mu,
  output logic [1:0]                   status,
  output logic [7:0]                   error_code
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
  localparam int SUM_W = MU_WIDTH + CH_W;

  state_t              state_reg, state_next;
  logic [7:0]          err_reg, err_next;
  logic [MU_WIDTH-1:0] mu_reg;
  logic [MU_WIDTH-1:0] q_mu_reg;
  logic [MU_WIDTH-1:0] mod_mem [NUM_MODULES];

  logic [NUM_CH-1:0]     acc;
  logic [COST_WIDTH-1:0] cost [NUM_CH];
  logic [MOD_W-1:0]      tgt  [NUM_CH];
  logic [NUM_CH-1:0]     mod_we;
  logic [NUM_CH-1:0]     mod_ovf;
  logic [MU_WIDTH-1:0]   mod_new [NUM_CH];

  logic [SUM_W-1:0]    s_total;
  logic                any_acc;
  logic [MU_WIDTH-1:0] mu_sum;
  logic                mu_ovf;
  logic                over_budget;
  logic                commit;
  logic                saturate;

  // Per-channel decode plus a merged per-module increment. When several channels hit the
  // same module, the lowest-numbered one owns the write and carries the combined cost.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SUM_W-1:0] add_g;
      logic             we_g;

      assign cost[gi] = chg_cost[gi*COST_WIDTH +: COST_WIDTH];
      assign tgt[gi]  = chg_module[gi*MOD_W +: MOD_W];
      assign acc[gi]  = chg_valid[gi] & chg_ready;

      always_comb begin
        add_g = '0;
        we_g  = acc[gi];
        for (int c = 0; c < NUM_CH; c++) begin
          if (acc[c] && (tgt[c] == tgt[gi])) begin
            add_g = add_g + SUM_W'(cost[c]);
            if (c < gi) begin
              we_g = 1'b0;
            end
          end
        end
      end

      assign mod_we[gi] = we_g;

      mu_sat_add #(
        .W  (MU_WIDTH),
        .BW (SUM_W)
      ) u_mod_add (
        .a   (mod_mem[tgt[gi]]),
        .b   (add_g),
        .sum (mod_new[gi]),
        .ovf (mod_ovf[gi])
      );
    end
  endgenerate

  always_comb begin
    s_total = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (acc[c]) begin
        s_total = s_total + SUM_W'(cost[c]);
      end
    end
  end

  assign any_acc = |acc;

  mu_sat_add #(
    .W  (MU_WIDTH),
    .BW (SUM_W)
  ) u_mu_add (
    .a   (mu_reg),
    .b   (s_total),
    .sum (mu_sum),
    .ovf (mu_ovf)
  );

  // An overflowing total is necessarily above any representable budget.
  assign over_budget = any_acc && budget_en && (mu_ovf || (mu_sum > budget));
  assign commit      = any_acc && !over_budget && !clear;
  assign saturate    = commit && (mu_ovf || |(mod_ovf & mod_we));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      err_reg   <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (over_budget) begin
            state_next = ST_EXHAUSTED;
          end else if (saturate) begin
            state_next = ST_SATURATED;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    chg_ready = (state_reg == ST_RUN);
    status    = state_reg;
  end

  always_comb begin
    err_next = err_reg;
    if (clear) begin
      err_next = ERR_NONE;
    end else if (err_reg == ERR_NONE) begin
      if (over_budget) begin
        err_next = ERR_BUDGET;
      end else if (saturate) begin
        err_next = ERR_SATURATE;
      end
    end
  end

  // The query port reads before this cycle's commit lands, so it shows the previous edge.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      mu_reg   <= '0;
      q_mu_reg <= '0;
      for (int k = 0; k < NUM_MODULES; k++) begin
        mod_mem[k] <= '0;
      end
    end else begin
      q_mu_reg <= mod_mem[q_module];
      if (commit) begin
        mu_reg <= mu_sum;
        for (int c = 0; c < NUM_CH; c++) begin
          if (mod_we[c]) begin
            mod_mem[tgt[c]] <= mod_new[c];
          end
        end
      end
    end
  end

  assign mu         = mu_reg;
  assign q_mu       = q_mu_reg;
  assign error_code = err_reg;

endmodule
